wb_port_arbiter: RTL

- Shares the single register-file write port between two sources: the in-order WB stage (fed by the MEM/WB pipeline register) and a late-completion requester, such as a multi-cycle divider or out-of-band load return.
- WB always wins, because the MEM/WB stage cannot stall.
- Late results wait in a small FIFO until a free write slot appears.
- A starvation counter raises a stall request so the pipeline front-end injects a bubble.
- A pending-destination mask is exported to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the in-order WB
//            stage and a late-completion requester. WB always wins. Late
//            results wait in a small FIFO, and a starvation counter requests
//            a front-end bubble. The destinations still held in the FIFO are
//            exported as a mask for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lt_valid,
  output logic            lt_ready,
  input  logic [4:0]      lt_rd,
  input  logic [XLEN-1:0] lt_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall_req,
  output logic [31:0]     pend_mask,
  output logic            lt_drain
);

  localparam int         C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_AW:0] C_DEPTH = (C_AW+1)'(DEPTH);
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic [C_AW:0]   count_q, count_d;
  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            stall_req_q, stall_req_d;
  logic [31:0]     pend_mask_q, pend_mask_d;

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic            w_wb_hit, w_full, w_empty, w_push, w_drain;
  logic [C_AW-1:0] w_idx;
  logic [4:0]      w_ent_rd;

  assign w_wb_hit = wb_valid & wb_reg_write & (wb_rd != 5'd0);
  assign w_full   = (count_q == C_DEPTH);
  assign w_empty  = (count_q == '0);
  // Acceptance depends only on the registered count, so a same-cycle drain never frees a slot.
  assign lt_ready = reset_n & ~w_full;
  // A result for x0 is accepted but never stored.
  assign w_push   = lt_valid & lt_ready & (lt_rd != 5'd0);
  assign w_drain  = reset_n & ~w_wb_hit & ~w_empty;

  // Write-port mux: WB first, then the FIFO head, otherwise idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    lt_drain = w_drain;
    if (reset_n) begin
      if (w_wb_hit) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (!w_empty) begin
        rf_we    = 1'b1;
        rf_waddr = rd_mem_q[rd_ptr_q];
        rf_wdata = data_mem_q[rd_ptr_q];
      end
    end
  end

  // Next FIFO bookkeeping, pending mask and starvation tracking.
  always_comb begin
    count_d  = count_q + {{C_AW{1'b0}}, w_push} - {{C_AW{1'b0}}, w_drain};
    wr_ptr_d = w_push  ? wr_ptr_q + C_AW'(1) : wr_ptr_q;
    rd_ptr_d = w_drain ? rd_ptr_q + C_AW'(1) : rd_ptr_q;

    // The mask covers the entries valid after this edge. The slot being
    // pushed is free now, so its rd comes from the input, not the RAM.
    pend_mask_d = '0;
    w_idx       = '0;
    w_ent_rd    = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = rd_ptr_d + C_AW'(i);
      if ((C_AW+1)'(i) < count_d) begin
        w_ent_rd = (w_push && (w_idx == wr_ptr_q)) ? lt_rd : rd_mem_q[w_idx];
        pend_mask_d[w_ent_rd] = 1'b1;
      end
    end

    starve_cnt_d = starve_cnt_q;
    if (w_drain || w_empty) begin
      starve_cnt_d = 4'd0;
    end else if (w_wb_hit) begin
      starve_cnt_d = (starve_cnt_q >= C_LIMIT) ? C_LIMIT : starve_cnt_q + 4'd1;
    end

    stall_req_d = stall_req_q;
    if (w_drain) begin
      stall_req_d = 1'b0;
    end else if (!w_empty && w_wb_hit &&
                 (({1'b0, starve_cnt_q} + 5'd1) >= {1'b0, C_LIMIT})) begin
      stall_req_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_cnt_q <= 4'd0;
      stall_req_q  <= 1'b0;
      pend_mask_q  <= 32'd0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      stall_req_q  <= stall_req_d;
      pend_mask_q  <= pend_mask_d;
    end
  end

  // Entry storage; contents are only meaningful under the valid count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      rd_mem_q[wr_ptr_q]   <= lt_rd;
      data_mem_q[wr_ptr_q] <= lt_data;
    end
  end

  assign stall_req = stall_req_q;
  assign pend_mask = pend_mask_q;

endmodule
`default_nettype wire
